seq_booth_multiplier: RTL and testbench
=======================================

SEQ_BOOTH_MULTIPLIER -- requirements
Module: seq_booth_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width (even, >= 4).
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port start  input  1  request a multiply; sampled only while ready=1.
REQ-005 SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-006 SHALL have port A  input  WIDTH  multiplicand; sampled with start.
REQ-007 SHALL have port B  input  WIDTH  multiplier; sampled with start.
REQ-008 SHALL have port P  output  2*WIDTH  product register.
REQ-009 SHALL have port ready  output  1  high in IDLE only.
REQ-010 SHALL have port done  output  1  one-cycle pulse when P is updated.

Function
REQ-011 SHALL use FSM states IDLE, CALC, DONE.
REQ-012 IDLE: start=1 on a clock edge SHALL capture A, B and signed_mode, clear the accumulator, and move to CALC.
REQ-013 Capture SHALL extend operands to WIDTH+2 bits: sign-extend if signed_mode=1, zero-extend otherwise.
REQ-014 CALC SHALL retire 2 multiplier bits per cycle with radix-4 Booth recoding (digits 0, +-1, +-2 times A), running exactly WIDTH/2+1 cycles, then move to DONE.
REQ-015 DONE SHALL load P with the low 2*WIDTH bits of the result, assert done for that cycle, and return to IDLE.
REQ-016 Latency: done SHALL assert exactly WIDTH/2+2 cycles after the accepting edge; WIDTH=16 gives 10.
REQ-017 P SHALL hold its value from DONE until the next DONE.
REQ-018 start while ready=0 SHALL be ignored, not queued. Changes to A, B or signed_mode during CALC or DONE SHALL have no effect.
REQ-019 If start is held high continuously, a new operation SHALL be accepted on each IDLE cycle, giving back-to-back operations every WIDTH/2+3 cycles.
REQ-020 The result SHALL be exact for all operand values, including most-negative times most-negative in signed mode and all-ones times all-ones in unsigned mode.

Reset
REQ-021 Asserting reset, including mid-CALC, SHALL immediately force IDLE, P=0, done=0, ready=1, and clear internal registers.
REQ-022 After reset deasserts, the first start SHALL be accepted normally.

Configuration
REQ-023 Macro MULT_ACC_EN SHALL add port acc (input, 1 bit, sampled with start).
REQ-024 With MULT_ACC_EN defined and acc=1, DONE SHALL load P = P + product, modulo 2^(2*WIDTH). With acc=0, P SHALL equal the product.
REQ-025 Without MULT_ACC_EN, the acc port and the adder SHALL not exist, and P SHALL always equal the product.

Structure
REQ-026 Package mult_pkg SHALL hold the FSM state typedef, the Booth digit typedef (ZERO, POS1, POS2, NEG1, NEG2), and the iteration-count function of WIDTH.
REQ-027 Sub-module booth_recoder SHALL be combinational: it maps 3 multiplier bits to a Booth digit.

Verification
REQ-028 WIDTH=16, unsigned, A=1512, B=201 -> done 10 cycles after accept, P=303912 (0x0004A328).
REQ-029 Signed, A=-1512 (0xFA18), B=201 -> P=0xFFFB5CD8. Signed, A=B=0x8000 -> P=0x40000000.
REQ-030 Unsigned, A=B=0xFFFF -> P=0xFFFE0001. Signed, same operands -> P=0x00000001.
REQ-031 Pulse start again 3 cycles after accept, with different operands -> ignored, P and latency unchanged.
REQ-032 Assert reset 4 cycles into CALC -> P=0 and ready=1 immediately. Next start with A=192, B=128 -> P=24576.
REQ-033 MULT_ACC_EN: run 1512*201, then acc=1 with 207*810 -> P=471582.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types for the sequential Booth multiplier: FSM states, radix-4 digits
// and the iteration count as a function of operand width.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  // Operands are widened to width+2 bits, giving (width+2)/2 radix-4 digits.
  function automatic int booth_iters(input int width);
    return width / 2 + 1;
  endfunction

endpackage

// File: rtl/booth_recoder.sv
// Combinational radix-4 Booth recoder: {b[2i+1], b[2i], b[2i-1]} -> digit.
module booth_recoder
  import mult_pkg::*;
(
  input  logic [2:0]   i_bits,
  output booth_digit_t o_digit
);

  always_comb begin
    o_digit = ZERO;
    case (i_bits)
      3'b001, 3'b010: o_digit = POS1;
      3'b011:         o_digit = POS2;
      3'b100:         o_digit = NEG2;
      3'b101, 3'b110: o_digit = NEG1;
      default:        o_digit = ZERO;
    endcase
  end

endmodule

// File: rtl/seq_booth_multiplier.sv
// Sequential radix-4 Booth multiplier: WIDTH/2+1 CALC cycles, done WIDTH/2+2 cycles after accept.
// Optional macro MULT_ACC_EN adds input acc so the DONE state can accumulate into P.
module seq_booth_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
`ifdef MULT_ACC_EN
  input  logic               acc,
`endif
  input  logic [WIDTH-1:0]   A,
  input  logic [WIDTH-1:0]   B,
  output logic [2*WIDTH-1:0] P,
  output logic               ready,
  output logic               done
);

  localparam int PW    = 2 * WIDTH;
  localparam int ITERS = booth_iters(WIDTH);
  localparam int CW    = $clog2(ITERS + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_p;
  logic [WIDTH+2:0] r_mplier;
  logic [CW-1:0]    r_cnt;
  logic             r_done;
  logic [WIDTH+1:0] w_a_ext;
  logic [WIDTH+1:0] w_b_ext;
  logic [PW-1:0]    w_term;
  booth_digit_t     w_digit;
`ifdef MULT_ACC_EN
  logic             r_acc_en;
`endif

  assign w_a_ext = signed_mode ? {{2{A[WIDTH-1]}}, A} : {2'b00, A};
  assign w_b_ext = signed_mode ? {{2{B[WIDTH-1]}}, B} : {2'b00, B};

  booth_recoder u_recoder (
    .i_bits  (r_mplier[2:0]),
    .o_digit (w_digit)
  );

  // Partial products are summed modulo 2^PW; only the low 2*WIDTH bits are kept.
  always_comb begin
    w_term = '0;
    case (w_digit)
      POS1:    w_term = r_mcand;
      POS2:    w_term = r_mcand << 1;
      NEG1:    w_term = -r_mcand;
      NEG2:    w_term = -(r_mcand << 1);
      default: w_term = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (r_cnt == LAST_CNT) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_p      <= '0;
      r_done   <= 1'b0;
`ifdef MULT_ACC_EN
      r_acc_en <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_mcand  <= {{(WIDTH-2){w_a_ext[WIDTH+1]}}, w_a_ext};
            r_mplier <= {w_b_ext, 1'b0};
            r_acc    <= '0;
            r_cnt    <= '0;
`ifdef MULT_ACC_EN
            r_acc_en <= acc;
`endif
          end
        end
        CALC: begin
          r_acc    <= r_acc + w_term;
          r_mcand  <= r_mcand << 2;
          r_mplier <= r_mplier >> 2;
          r_cnt    <= r_cnt + 1'b1;
        end
        DONE: begin
`ifdef MULT_ACC_EN
          r_p <= r_acc_en ? (r_p + r_acc) : r_acc;
`else
          r_p <= r_acc;
`endif
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign P     = r_p;
  assign ready = (r_state == IDLE);
  assign done  = r_done;

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// Directed bench for seq_booth_multiplier (WIDTH=16): products, latency, ignored starts,
// reset mid-operation, back-to-back throughput and, with MULT_ACC_EN, accumulation.
module tb_seq_booth_multiplier;

  localparam int W = 16;

  logic           clock = 1'b0;
  logic           reset = 1'b0;
  logic           start = 1'b0;
  logic           signed_mode = 1'b0;
  logic [W-1:0]   A = '0;
  logic [W-1:0]   B = '0;
  logic [2*W-1:0] P;
  logic           ready;
  logic           done;
`ifdef MULT_ACC_EN
  logic           acc = 1'b0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seq_booth_multiplier #(.WIDTH(W)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .signed_mode (signed_mode),
`ifdef MULT_ACC_EN
    .acc         (acc),
`endif
    .A           (A),
    .B           (B),
    .P           (P),
    .ready       (ready),
    .done        (done)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Launches one operation and returns edges from accept to done (-1 on timeout).
  task automatic do_op(input logic sm, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic acc_bit, output int lat);
    signed_mode = sm;
    A = a;
    B = b;
`ifdef MULT_ACC_EN
    acc = acc_bit;
`endif
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    if (done !== 1'b1) lat = -1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_tests++; if (P !== 32'h0)  begin n_fail++; $display("FAIL reset_P got %h want %h", P, 32'h0); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", ready); end
    n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unsigned();
    int lat;
    do_op(1'b0, 16'd1512, 16'd201, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL unsigned_latency got %0d want 10", lat); end
    n_tests++; if (P !== 32'h0004A328) begin n_fail++; $display("FAIL unsigned_P got %h want %h", P, 32'h0004A328); end
    tick();
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_pulse got %b want 0", done); end
    A = 16'h1111;
    B = 16'h2222;
    repeat (5) tick();
    n_tests++; if (P !== 32'h0004A328) begin n_fail++; $display("FAIL P_hold got %h want %h", P, 32'h0004A328); end
  endtask

  task automatic test_signed();
    int lat;
    do_op(1'b1, 16'hFA18, 16'd201, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL signed_neg_latency got %0d want 10", lat); end
    n_tests++; if (P !== 32'hFFFB5CD8) begin n_fail++; $display("FAIL signed_neg_P got %h want %h", P, 32'hFFFB5CD8); end
    tick();
    do_op(1'b1, 16'h8000, 16'h8000, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL signed_min_latency got %0d want 10", lat); end
    n_tests++; if (P !== 32'h40000000) begin n_fail++; $display("FAIL signed_min_P got %h want %h", P, 32'h40000000); end
    tick();
  endtask

  task automatic test_extremes();
    int lat;
    do_op(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL uns_ones_latency got %0d want 10", lat); end
    n_tests++; if (P !== 32'hFFFE0001) begin n_fail++; $display("FAIL uns_ones_P got %h want %h", P, 32'hFFFE0001); end
    tick();
    do_op(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, lat);
    n_tests++; if (P !== 32'h00000001) begin n_fail++; $display("FAIL sgn_ones_P got %h want %h", P, 32'h00000001); end
    tick();
    do_op(1'b1, 16'h7FFF, 16'h8000, 1'b0, lat);
    n_tests++; if (P !== 32'hC0008000) begin n_fail++; $display("FAIL sgn_maxmin_P got %h want %h", P, 32'hC0008000); end
    tick();
  endtask

  task automatic test_ignore_start();
    int lat;
    int extra;
    signed_mode = 1'b0;
    A = 16'd1512;
    B = 16'd201;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    n_tests++; if (ready !== 1'b0) begin n_fail++; $display("FAIL busy_ready got %b want 0", ready); end
    signed_mode = 1'b1;
    A = 16'h1234;
    B = 16'h0F0F;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 4;
    while (done !== 1'b1 && lat < 40) begin
      tick();
      lat++;
    end
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL ignore_latency got %0d want 10", lat); end
    n_tests++; if (P !== 32'h0004A328) begin n_fail++; $display("FAIL ignore_P got %h want %h", P, 32'h0004A328); end
    extra = 0;
    repeat (15) begin
      tick();
      if (done === 1'b1) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL ignore_not_queued got %0d want 0", extra); end
  endtask

  task automatic test_reset_mid();
    int lat;
    signed_mode = 1'b0;
    A = 16'd500;
    B = 16'd300;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    #1;
    n_tests++; if (P !== 32'h0)    begin n_fail++; $display("FAIL midreset_P got %h want %h", P, 32'h0); end
    n_tests++; if (ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready got %b want 1", ready); end
    n_tests++; if (done !== 1'b0)  begin n_fail++; $display("FAIL midreset_done got %b want 0", done); end
    @(posedge clock);
    #1 reset = 1'b0;
    tick();
    do_op(1'b0, 16'd192, 16'd128, 1'b0, lat);
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL post_reset_latency got %0d want 10", lat); end
    n_tests++; if (P !== 32'd24576) begin n_fail++; $display("FAIL post_reset_P got %0d want 24576", P); end
    tick();
  endtask

  task automatic test_back_to_back();
    int t;
    int first;
    int second;
    logic [2*W-1:0] p_first;
    first = -1;
    second = -1;
    p_first = '0;
    signed_mode = 1'b0;
    A = 16'd1512;
    B = 16'd201;
    start = 1'b1;
    t = 0;
    while (second < 0 && t < 60) begin
      tick();
      t++;
      if (done === 1'b1) begin
        if (first < 0) begin
          first = t;
          p_first = P;
          A = 16'd207;
          B = 16'd810;
        end else begin
          second = t;
        end
      end
    end
    start = 1'b0;
    n_tests++; if (first !== 11) begin n_fail++; $display("FAIL b2b_first_done got %0d want 11", first); end
    n_tests++; if (second - first !== 11) begin n_fail++; $display("FAIL b2b_interval got %0d want 11", second - first); end
    n_tests++; if (p_first !== 32'd303912) begin n_fail++; $display("FAIL b2b_P1 got %0d want 303912", p_first); end
    n_tests++; if (P !== 32'd167670) begin n_fail++; $display("FAIL b2b_P2 got %0d want 167670", P); end
    repeat (15) tick();
  endtask

`ifdef MULT_ACC_EN
  task automatic test_accumulate();
    int lat;
    do_op(1'b0, 16'd1512, 16'd201, 1'b0, lat);
    n_tests++; if (P !== 32'd303912) begin n_fail++; $display("FAIL acc_first_P got %0d want 303912", P); end
    tick();
    do_op(1'b0, 16'd207, 16'd810, 1'b1, lat);
    n_tests++; if (P !== 32'd471582) begin n_fail++; $display("FAIL acc_sum_P got %0d want 471582", P); end
    n_tests++; if (lat !== 10) begin n_fail++; $display("FAIL acc_latency got %0d want 10", lat); end
    tick();
    do_op(1'b0, 16'd3, 16'd4, 1'b0, lat);
    n_tests++; if (P !== 32'd12) begin n_fail++; $display("FAIL acc_clear_P got %0d want 12", P); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_extremes();
    test_ignore_start();
    test_reset_mid();
    test_back_to_back();
`ifdef MULT_ACC_EN
    test_accumulate();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
